// File: rtl/qeciphy_tx_framer.sv
// qeciphy_tx_framer: QECIPHY transmit framer.
// Builds 64-slot frames (slot 0 = FAW, then groups of 6 data + 1 CRC slot),
// presents a stage-1 view to the CRC engine and inserts the returned CRC
// fields into the CRC slot of the CRC_LAT-delayed output stream.
// Optional feature macro: QECIPHY_TX_FRAMER_CRC_MONITOR_EN (sticky missing-CRC flag).
module qeciphy_tx_framer #(
  parameter logic [63:0] FAW_WORD  = 64'hF0F0_CCAA_5533_0F0F,
  parameter logic [63:0] IDLE_WORD = 64'h0,
  parameter int unsigned CRC_LAT   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [63:0] s_tdata_i,
  input  logic        s_tvalid_i,
  output logic        s_tready_o,
  output logic [63:0] s1_tdata_o,
  output logic        s1_faw_boundary_o,
  output logic        s1_crc_boundary_o,
  input  logic [15:0] crc01_i,
  input  logic [15:0] crc23_i,
  input  logic [15:0] crc45_i,
  input  logic [7:0]  crcvw_i,
  input  logic        crc_valid_i,
  output logic [63:0] tx_tdata_o,
  output logic        tx_faw_boundary_o,
  output logic        tx_crc_boundary_o,
  output logic        crc_missing_o
);

  localparam int unsigned DW = 64;
  localparam int unsigned SW = 6;
  localparam int unsigned GW = 3;
  localparam int unsigned EW = DW + 2;          // {faw, crc, data}
  localparam int unsigned PW = CRC_LAT * EW;
  localparam logic [SW-1:0] LAST_SLOT = SW'(63);
  localparam logic [GW-1:0] CRC_GRP   = GW'(6);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [DW-1:0] s1_data_d;
  logic          s1_faw_d, s1_crc_d;

  // Next-state, slot/group sequencing and stage-1 word selection.
  // slot_q/grp_q describe the slot that the next edge loads into stage 1.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    grp_d      = grp_q;
    s1_data_d  = IDLE_WORD;
    s1_faw_d   = 1'b0;
    s1_crc_d   = 1'b0;
    s_tready_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d   = RUN;
          slot_d    = SW'(1);
          grp_d     = '0;
          s1_data_d = FAW_WORD;
          s1_faw_d  = 1'b1;
        end
      end
      RUN: begin
        slot_d = slot_q + SW'(1);
        if (slot_q == '0) begin
          grp_d     = '0;
          s1_data_d = FAW_WORD;
          s1_faw_d  = 1'b1;
        end else begin
          grp_d = (grp_q == CRC_GRP) ? '0 : grp_q + GW'(1);
          if (grp_q == CRC_GRP) begin
            s1_data_d = '0;
            s1_crc_d  = 1'b1;
          end else begin
            s_tready_o = 1'b1;
            if (s_tvalid_i) s1_data_d = s_tdata_i;
          end
        end
        // Frames always complete; enable is only looked at on slot 63.
        if ((slot_q == LAST_SLOT) && !enable_i) begin
          state_d = IDLE;
          slot_d  = '0;
          grp_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // No payload handshake while reset is being applied.
    if (rst_i) s_tready_o = 1'b0;
  end

  // State, counters and stage-1 registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= IDLE;
      slot_q            <= '0;
      grp_q             <= '0;
      s1_tdata_o        <= IDLE_WORD;
      s1_faw_boundary_o <= 1'b0;
      s1_crc_boundary_o <= 1'b0;
    end else begin
      state_q           <= state_d;
      slot_q            <= slot_d;
      grp_q             <= grp_d;
      s1_tdata_o        <= s1_data_d;
      s1_faw_boundary_o <= s1_faw_d;
      s1_crc_boundary_o <= s1_crc_d;
    end
  end

  logic [PW-1:0] pipe_q;
  logic [EW-1:0] s1_elem;
  logic [EW-1:0] tx_elem;

  assign s1_elem = {s1_faw_boundary_o, s1_crc_boundary_o, s1_tdata_o};
  assign tx_elem = pipe_q[PW-1 -: EW];

  // Delay line matching the CRC engine latency; oldest entry is the tx slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_q <= {CRC_LAT{{2'b00, IDLE_WORD}}};
    end else begin
      pipe_q <= (pipe_q << EW) | PW'(s1_elem);
    end
  end

  logic [15:0] crc01_q, crc23_q, crc45_q;
  logic [7:0]  crcvw_q;

  // Hold the most recent CRC engine result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc01_q <= '0;
      crc23_q <= '0;
      crc45_q <= '0;
      crcvw_q <= '0;
    end else if (crc_valid_i) begin
      crc01_q <= crc01_i;
      crc23_q <= crc23_i;
      crc45_q <= crc45_i;
      crcvw_q <= crcvw_i;
    end
  end

  logic [DW-1:0] crc_word;

  // Same-cycle CRC result bypasses the holding registers.
  always_comb begin
    crc_word = {8'h00, crcvw_q, crc45_q, crc23_q, crc01_q};
    if (crc_valid_i) crc_word = {8'h00, crcvw_i, crc45_i, crc23_i, crc01_i};
  end

  assign tx_faw_boundary_o = tx_elem[EW-1];
  assign tx_crc_boundary_o = tx_elem[EW-2];
  assign tx_tdata_o        = tx_elem[EW-2] ? crc_word : tx_elem[DW-1:0];

`ifdef QECIPHY_TX_FRAMER_CRC_MONITOR_EN
  logic fresh_q;

  // Track whether a CRC result arrived since the last emitted CRC slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fresh_q       <= 1'b0;
      crc_missing_o <= 1'b0;
    end else if (tx_elem[EW-2]) begin
      fresh_q <= 1'b0;
      if (!fresh_q && !crc_valid_i) crc_missing_o <= 1'b1;
    end else if (crc_valid_i) begin
      fresh_q <= 1'b1;
    end
  end
`else
  assign crc_missing_o = 1'b0;
`endif

endmodule

// File: tb/tb_qeciphy_tx_framer.sv
// Self-checking bench for qeciphy_tx_framer with a registered CRC engine model.
module tb_qeciphy_tx_framer;

  localparam logic [63:0] FAW  = 64'hF0F0_CCAA_5533_0F0F;
  localparam logic [63:0] IDLE = 64'h0;
  localparam int unsigned LAT  = 1;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [63:0] s_tdata_i;
  logic        s_tvalid_i;
  logic        s_tready_o;
  logic [63:0] s1_tdata_o;
  logic        s1_faw_boundary_o;
  logic        s1_crc_boundary_o;
  logic [15:0] crc01_i = '0;
  logic [15:0] crc23_i = '0;
  logic [15:0] crc45_i = '0;
  logic [7:0]  crcvw_i = '0;
  logic        crc_valid_i = 1'b0;
  logic [63:0] tx_tdata_o;
  logic        tx_faw_boundary_o;
  logic        tx_crc_boundary_o;
  logic        crc_missing_o;

  always #5 clk_i = ~clk_i;

  qeciphy_tx_framer #(.FAW_WORD(FAW), .IDLE_WORD(IDLE), .CRC_LAT(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .s_tdata_i(s_tdata_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o),
    .s1_tdata_o(s1_tdata_o), .s1_faw_boundary_o(s1_faw_boundary_o),
    .s1_crc_boundary_o(s1_crc_boundary_o),
    .crc01_i(crc01_i), .crc23_i(crc23_i), .crc45_i(crc45_i), .crcvw_i(crcvw_i),
    .crc_valid_i(crc_valid_i), .tx_tdata_o(tx_tdata_o),
    .tx_faw_boundary_o(tx_faw_boundary_o), .tx_crc_boundary_o(tx_crc_boundary_o),
    .crc_missing_o(crc_missing_o)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] pay_cnt;
  logic [63:0] exp_data_q[$];
  logic [63:0] s1_q[$];
  logic [63:0] exp_crc_q[$];
  bit          trk_on = 1'b0;
  bit          mon_en = 1'b0;
  bit          eng_en = 1'b1;
  int          slot_b = 0;
  int unsigned eng_cnt;

  // Payload acceptance scoreboard and registered CRC engine model.
  always @(posedge clk_i) begin : drv_eng
    logic [15:0] c01, c23, c45;
    logic [7:0]  cvw;
    if (rst_i) begin
      pay_cnt <= 64'd1;
      exp_data_q.delete();
      s1_q.delete();
      exp_crc_q.delete();
      crc_valid_i <= 1'b0;
      eng_cnt <= 0;
    end else begin
      if (s_tready_o && s_tvalid_i) begin
        exp_data_q.push_back(s_tdata_i);
        s1_q.push_back(s_tdata_i);
        pay_cnt <= pay_cnt + 64'd1;
      end
      crc_valid_i <= eng_en && s1_crc_boundary_o;
      if (eng_en && s1_crc_boundary_o) begin
        c01 = 16'hA000 + 16'(eng_cnt);
        c23 = 16'hB100 + 16'(eng_cnt);
        c45 = 16'hC200 + 16'(eng_cnt);
        cvw = 8'h5A ^ 8'(eng_cnt);
        crc01_i <= c01;
        crc23_i <= c23;
        crc45_i <= c45;
        crcvw_i <= cvw;
        exp_crc_q.push_back({8'h00, cvw, c45, c23, c01});
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  bit          exp_f, exp_c;
  logic [63:0] w;

  // Stage-1 slot pattern and tx scoreboard, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (trk_on) begin
      exp_f = (slot_b == 0);
      exp_c = (slot_b != 0) && (slot_b % 7 == 0);
      n_checks++;
      if (s1_faw_boundary_o !== exp_f || s1_crc_boundary_o !== exp_c) begin
        n_errors++;
        $display("FAIL s1_flags slot %0d: got faw=%b crc=%b want faw=%b crc=%b",
                 slot_b, s1_faw_boundary_o, s1_crc_boundary_o, exp_f, exp_c);
      end
      if (exp_f) begin
        n_checks++;
        if (s1_tdata_o !== FAW) begin
          n_errors++; $display("FAIL s1_faw_word: got %h want %h", s1_tdata_o, FAW);
        end
      end else if (exp_c) begin
        n_checks++;
        if (s1_tdata_o !== 64'd0) begin
          n_errors++; $display("FAIL s1_crc_word slot %0d: got %h want 0", slot_b, s1_tdata_o);
        end
      end else if (s1_tdata_o !== IDLE) begin
        n_checks++;
        if (s1_q.size() == 0) begin
          n_errors++; $display("FAIL s1_extra_data slot %0d: got %h want idle", slot_b, s1_tdata_o);
        end else begin
          w = s1_q.pop_front();
          if (s1_tdata_o !== w) begin
            n_errors++; $display("FAIL s1_data slot %0d: got %h want %h", slot_b, s1_tdata_o, w);
          end
        end
      end
      slot_b = (slot_b + 1) % 64;
    end
    if (mon_en) begin
      if (tx_faw_boundary_o === 1'b1) begin
        n_checks++;
        if (tx_tdata_o !== FAW || tx_crc_boundary_o !== 1'b0) begin
          n_errors++; $display("FAIL tx_faw: got %h crc=%b want %h crc=0", tx_tdata_o, tx_crc_boundary_o, FAW);
        end
      end else if (tx_crc_boundary_o === 1'b1) begin
        n_checks++;
        if (exp_crc_q.size() == 0) begin
          n_errors++; $display("FAIL tx_crc_extra: got %h want none", tx_tdata_o);
        end else begin
          w = exp_crc_q.pop_front();
          if (tx_tdata_o !== w) begin
            n_errors++; $display("FAIL tx_crc_word: got %h want %h", tx_tdata_o, w);
          end
        end
      end else if (tx_tdata_o !== IDLE) begin
        n_checks++;
        if (exp_data_q.size() == 0) begin
          n_errors++; $display("FAIL tx_extra_data: got %h want idle", tx_tdata_o);
        end else begin
          w = exp_data_q.pop_front();
          if (tx_tdata_o !== w) begin
            n_errors++; $display("FAIL tx_data: got %h want %h", tx_tdata_o, w);
          end
        end
      end
    end
  end

  // Advance one clock; inputs are updated shortly after the rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #2;
    s_tdata_i = pay_cnt;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; enable_i = 1'b1; s_tvalid_i = 1'b1; s_tdata_i = 64'd0;
    trk_on = 1'b0; mon_en = 1'b0; eng_en = 1'b1;
    repeat (3) cyc();
    n_checks++;
    if (tx_faw_boundary_o !== 1'b0 || tx_crc_boundary_o !== 1'b0) begin
      n_errors++; $display("FAIL reset_tx_flags: got %b%b want 00", tx_faw_boundary_o, tx_crc_boundary_o);
    end
    n_checks++;
    if (tx_tdata_o !== IDLE) begin
      n_errors++; $display("FAIL reset_tx_data: got %h want %h", tx_tdata_o, IDLE);
    end
    n_checks++;
    if (s_tready_o !== 1'b0) begin
      n_errors++; $display("FAIL reset_tready: got %b want 0", s_tready_o);
    end
    n_checks++;
    if (s1_faw_boundary_o !== 1'b0 || s1_crc_boundary_o !== 1'b0 || s1_tdata_o !== IDLE) begin
      n_errors++; $display("FAIL reset_s1: got %b%b %h want 00 %h", s1_faw_boundary_o, s1_crc_boundary_o, s1_tdata_o, IDLE);
    end
    n_checks++;
    if (crc_missing_o !== 1'b0) begin
      n_errors++; $display("FAIL reset_missing: got %b want 0", crc_missing_o);
    end
    rst_i = 1'b0;
    cyc();
    n_checks++;
    if (s1_tdata_o !== FAW || s1_faw_boundary_o !== 1'b1 || s1_crc_boundary_o !== 1'b0) begin
      n_errors++; $display("FAIL first_faw: got %h faw=%b crc=%b want %h faw=1 crc=0",
                           s1_tdata_o, s1_faw_boundary_o, s1_crc_boundary_o, FAW);
    end
    slot_b = 0; trk_on = 1'b1; mon_en = 1'b1;
  endtask

  task automatic test_continuous();
    for (int k = 0; k < 64; k++) begin
      int nxt;
      bit exp_rdy;
      nxt = (slot_b + 1) % 64;
      exp_rdy = (nxt % 7) != 0;
      n_checks++;
      if (s_tready_o !== exp_rdy) begin
        n_errors++; $display("FAIL tready slot %0d: got %b want %b", nxt, s_tready_o, exp_rdy);
      end
      if (slot_b == 1) begin
        n_checks++;
        if (s1_tdata_o !== 64'd1) begin
          n_errors++; $display("FAIL first_payload: got %h want 1", s1_tdata_o);
        end
      end
      if (slot_b == 62) begin
        n_checks++;
        if (s1_tdata_o !== 64'd54) begin
          n_errors++; $display("FAIL last_payload_frame1: got %h want 54", s1_tdata_o);
        end
      end
      cyc();
    end
    n_checks++;
    if (s1_faw_boundary_o !== 1'b1 || s1_tdata_o !== FAW) begin
      n_errors++; $display("FAIL frame2_faw: got faw=%b %h want faw=1 %h", s1_faw_boundary_o, s1_tdata_o, FAW);
    end
  endtask

  task automatic test_idle_gap();
    logic [63:0] gap_next;
    for (int g = 0; g < 70 && slot_b != 2; g++) cyc();
    gap_next = pay_cnt;
    s_tvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (s1_tdata_o !== IDLE || s1_faw_boundary_o !== 1'b0 || s1_crc_boundary_o !== 1'b0) begin
        n_errors++; $display("FAIL gap_slot%0d: got %h want %h", 3 + i, s1_tdata_o, IDLE);
      end
    end
    s_tvalid_i = 1'b1;
    cyc();
    n_checks++;
    if (s1_tdata_o !== gap_next) begin
      n_errors++; $display("FAIL gap_resume: got %h want %h", s1_tdata_o, gap_next);
    end
    for (int g = 0; g < 70 && slot_b != 0; g++) cyc();
  endtask

  task automatic test_enable_drop();
    for (int g = 0; g < 70 && slot_b != 19; g++) cyc();
    enable_i = 1'b0;
    for (int g = 0; g < 70 && slot_b != 30; g++) cyc();
    n_checks++;
    if (s_tready_o !== 1'b1) begin
      n_errors++; $display("FAIL drop_midframe_ready: got %b want 1", s_tready_o);
    end
    for (int g = 0; g < 70 && slot_b != 63; g++) cyc();
    n_checks++;
    if (s1_crc_boundary_o !== 1'b1) begin
      n_errors++; $display("FAIL drop_slot63_crc: got %b want 1", s1_crc_boundary_o);
    end
    @(negedge clk_i);
    #1;
    trk_on = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_checks++;
      if (s_tready_o !== 1'b0 || s1_faw_boundary_o !== 1'b0 || s1_crc_boundary_o !== 1'b0 || s1_tdata_o !== IDLE) begin
        n_errors++; $display("FAIL drop_idle cycle %0d: got rdy=%b faw=%b crc=%b %h want 0 0 0 %h",
                             i, s_tready_o, s1_faw_boundary_o, s1_crc_boundary_o, s1_tdata_o, IDLE);
      end
    end
    n_checks++;
    if (exp_data_q.size() != 0 || exp_crc_q.size() != 0 || s1_q.size() != 0) begin
      n_errors++; $display("FAIL drain: got pending data=%0d crc=%0d s1=%0d want 0 0 0",
                           exp_data_q.size(), exp_crc_q.size(), s1_q.size());
    end
    n_checks++;
    if (crc_missing_o !== 1'b0) begin
      n_errors++; $display("FAIL missing_low: got %b want 0", crc_missing_o);
    end
  endtask

  task automatic test_mid_reset();
    enable_i = 1'b1;
    cyc();
    n_checks++;
    if (s1_faw_boundary_o !== 1'b1) begin
      n_errors++; $display("FAIL restart_faw: got %b want 1", s1_faw_boundary_o);
    end
    slot_b = 0; trk_on = 1'b1;
    for (int g = 0; g < 70 && slot_b != 30; g++) cyc();
    rst_i = 1'b1; trk_on = 1'b0; mon_en = 1'b0;
    cyc();
    n_checks++;
    if (s1_faw_boundary_o !== 1'b0 || s1_crc_boundary_o !== 1'b0 || s1_tdata_o !== IDLE) begin
      n_errors++; $display("FAIL midreset_s1: got %b%b %h want 00 %h", s1_faw_boundary_o, s1_crc_boundary_o, s1_tdata_o, IDLE);
    end
    n_checks++;
    if (tx_faw_boundary_o !== 1'b0 || tx_crc_boundary_o !== 1'b0 || tx_tdata_o !== IDLE) begin
      n_errors++; $display("FAIL midreset_tx: got %b%b %h want 00 %h", tx_faw_boundary_o, tx_crc_boundary_o, tx_tdata_o, IDLE);
    end
    n_checks++;
    if (s_tready_o !== 1'b0) begin
      n_errors++; $display("FAIL midreset_tready: got %b want 0", s_tready_o);
    end
    rst_i = 1'b0; enable_i = 1'b0;
    cyc(); cyc();
    n_checks++;
    if (s1_tdata_o !== IDLE || s_tready_o !== 1'b0 || s1_faw_boundary_o !== 1'b0) begin
      n_errors++; $display("FAIL post_reset_idle: got %h rdy=%b faw=%b want %h 0 0", s1_tdata_o, s_tready_o, s1_faw_boundary_o, IDLE);
    end
  endtask

`ifdef QECIPHY_TX_FRAMER_CRC_MONITOR_EN
  task automatic test_crc_missing();
    eng_en = 1'b0; enable_i = 1'b1;
    cyc();
    n_checks++;
    if (s1_faw_boundary_o !== 1'b1) begin
      n_errors++; $display("FAIL miss_faw: got %b want 1", s1_faw_boundary_o);
    end
    slot_b = 0; trk_on = 1'b1;
    for (int g = 0; g < 70 && slot_b != 7; g++) cyc();
    cyc();
    n_checks++;
    if (tx_crc_boundary_o !== 1'b1 || tx_tdata_o !== 64'd0) begin
      n_errors++; $display("FAIL miss_crc_slot: got crc=%b %h want crc=1 0", tx_crc_boundary_o, tx_tdata_o);
    end
    n_checks++;
    if (crc_missing_o !== 1'b0) begin
      n_errors++; $display("FAIL miss_early: got %b want 0", crc_missing_o);
    end
    cyc();
    n_checks++;
    if (crc_missing_o !== 1'b1) begin
      n_errors++; $display("FAIL miss_rise: got %b want 1", crc_missing_o);
    end
    repeat (5) cyc();
    n_checks++;
    if (crc_missing_o !== 1'b1) begin
      n_errors++; $display("FAIL miss_sticky: got %b want 1", crc_missing_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_idle_gap();
    test_enable_drop();
    test_mid_reset();
`ifdef QECIPHY_TX_FRAMER_CRC_MONITOR_EN
    test_crc_missing();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
